// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath.
// Optional memory wait states are enabled with `define MEM_WAIT_EN (adds mem_ready).
module multicycle_controller #(
  parameter int unsigned ILLEGAL_HALT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       halted,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StJalr     = 4'd10,
    StBranch   = 4'd11,
    StUpper    = 4'd12,
    StHalt     = 4'd13
  } state_e;

  state_e state_q, state_d;
  logic   mem_rdy;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_rdy) state_d = StDecode;
      StDecode: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = StMemAdr;
          7'b0110011:             state_d = StExecR;
          7'b0010011:             state_d = StExecI;
          7'b1101111:             state_d = StJal;
          7'b1100111:             state_d = StJalr;
          7'b1100011:             state_d = StBranch;
          7'b0110111, 7'b0010111: state_d = StUpper;
          default:                state_d = (ILLEGAL_HALT != 0) ? StHalt : StFetch;
        endcase
      end
      StMemAdr:   state_d = (opcode == 7'b0000011) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_rdy) state_d = StMemWb;
      StMemWrite: if (mem_rdy) state_d = StFetch;
      StMemWb, StAluWb, StBranch: state_d = StFetch;
      StExecR, StExecI, StUpper:  state_d = StAluWb;
      StJalr:     state_d = StJal;
      StJal:      state_d = StAluWb;
      StHalt:     state_d = StHalt;
      default:    state_d = StFetch;  // unused codes 14-15 recover
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  logic pc_update, branch, ir_write, mem_write, reg_write;

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    halted    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      StFetch: begin
        ir_write  = mem_rdy;
        pc_update = mem_rdy;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      StMemAdr:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      StMemRead:  AdrSrc = 1'b1;
      StMemWb:    begin ResultSrc = 2'b01; reg_write = 1'b1; end
      StMemWrite: begin AdrSrc = 1'b1; mem_write = 1'b1; end
      StExecR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
      StExecI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      StAluWb:    reg_write = 1'b1;
      StJal:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      StJalr:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      StBranch:   begin ALUSrcA = 2'b10; ALUOp = 2'b01; branch = 1'b1; end
      StUpper: begin
        // lui adds the immediate to zero, auipc to the old PC
        ALUSrcA = (opcode == 7'b0110111) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
      StHalt:     halted = 1'b1;
      default:    ;
    endcase
  end

  // Reset masks the write enables so nothing commits while the FSM is being forced.
  assign PCWrite  = ~reset & (pc_update | (branch & branch_taken));
  assign IRWrite  = ~reset & ir_write;
  assign MemWrite = ~reset & mem_write;
  assign RegWrite = ~reset & reg_write;
  assign state    = state_q;

  always_comb begin
    case (opcode)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

endmodule
